// File: rtl/mtl2_multi_timer_if.sv
// Avalon-MM slave bus bundle for the multi-channel timer.
interface mtl2_multi_timer_if #(
  parameter int unsigned ADDR_W = 4
);
  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [31:0]       writedata;
  logic [31:0]       readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/mtl2_multi_timer.sv
// NUM_CH down-counting interval timers sharing one prescaler, with a global
// start/pending slot and a single level interrupt.
module mtl2_multi_timer #(
  parameter int unsigned NUM_CH         = 2,
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned PRESC_W        = 16,
  parameter int unsigned DEFAULT_PERIOD = 19999
) (
  input  logic                clk,
  input  logic                reset,
  mtl2_multi_timer_if.slave   bus,
  output logic                irq
);

  localparam int unsigned ADDR_W = $clog2(NUM_CH + 1) + 2;
  localparam int unsigned SLOT_W = ADDR_W - 2;

  // Bus decode
  logic              wr_c;
  logic              rd_c;
  logic              glob_c;
  logic [SLOT_W-1:0] slot_c;
  logic [1:0]        off_c;

  assign wr_c   = bus.chipselect & ~bus.write_n;
  assign rd_c   = bus.chipselect &  bus.write_n;
  assign slot_c = bus.address[ADDR_W-1:2];
  assign off_c  = bus.address[1:0];
  assign glob_c = (slot_c == SLOT_W'(NUM_CH));

  logic wr_pend_c;
  logic wr_gstart_c;
  logic wr_presc_c;

  assign wr_pend_c   = wr_c & glob_c & (off_c == 2'd0);
  assign wr_gstart_c = wr_c & glob_c & (off_c == 2'd1);
  assign wr_presc_c  = wr_c & glob_c & (off_c == 2'd2);

  // Timer state
  logic [CNT_W-1:0]   cnt_q    [NUM_CH];
  logic [CNT_W-1:0]   period_q [NUM_CH];
  logic [CNT_W-1:0]   snap_q   [NUM_CH];
  logic [NUM_CH-1:0]  run_q;
  logic [NUM_CH-1:0]  to_q;
  logic [NUM_CH-1:0]  ie_q;
  logic [NUM_CH-1:0]  cont_q;
  logic [NUM_CH-1:0]  reload_q;
  logic [PRESC_W-1:0] presc_q;
  logic [PRESC_W-1:0] pcnt_q;

  logic tick_c;
  assign tick_c = (pcnt_q == '0);

  logic [NUM_CH-1:0] wr_status_c;
  logic [NUM_CH-1:0] wr_ctrl_c;
  logic [NUM_CH-1:0] wr_period_c;
  logic [NUM_CH-1:0] wr_snap_c;
  logic [NUM_CH-1:0] fire_c;
  logic [NUM_CH-1:0] start_c;
  logic [NUM_CH-1:0] stop_c;
  logic [NUM_CH-1:0] clr_c;

  // Per-channel strobes and run/timeout events
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic sel_c;
    assign sel_c          = wr_c & (slot_c == SLOT_W'(g));
    assign wr_status_c[g] = sel_c & (off_c == 2'd0);
    assign wr_ctrl_c[g]   = sel_c & (off_c == 2'd1);
    assign wr_period_c[g] = sel_c & (off_c == 2'd2);
    assign wr_snap_c[g]   = sel_c & (off_c == 2'd3);
    assign fire_c[g]      = tick_c & run_q[g] & (cnt_q[g] == '0);
    // START beats every stop source, including a one-shot expiry.
    assign start_c[g]     = (wr_ctrl_c[g] & bus.writedata[2]) |
                            (wr_gstart_c & bus.writedata[g]);
    assign stop_c[g]      = (wr_ctrl_c[g] & bus.writedata[3]) | wr_period_c[g] |
                            (fire_c[g] & ~cont_q[g]);
    assign clr_c[g]       = wr_status_c[g] | (wr_pend_c & bus.writedata[g]);
  end

  // Read mux
  logic [31:0] rd_data_c;

  always_comb begin
    rd_data_c = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (slot_c == SLOT_W'(c)) begin
        case (off_c)
          2'd0:    rd_data_c[1:0]       = {run_q[c], to_q[c]};
          2'd1:    rd_data_c[1:0]       = {cont_q[c], ie_q[c]};
          2'd2:    rd_data_c[CNT_W-1:0] = period_q[c];
          default: rd_data_c[CNT_W-1:0] = snap_q[c];
        endcase
      end
    end
    if (glob_c) begin
      case (off_c)
        2'd0:    rd_data_c[NUM_CH-1:0]  = to_q;
        2'd2:    rd_data_c[PRESC_W-1:0] = presc_q;
        default: rd_data_c              = '0;
      endcase
    end
  end

  // Channel counters, flags and registers
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        cnt_q[c]    <= CNT_W'(DEFAULT_PERIOD);
        period_q[c] <= CNT_W'(DEFAULT_PERIOD);
        snap_q[c]   <= '0;
      end
      run_q    <= '0;
      to_q     <= '0;
      ie_q     <= '0;
      cont_q   <= '0;
      reload_q <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        // A PERIOD write forces the counter to the new value one cycle later.
        if (reload_q[c]) begin
          cnt_q[c] <= period_q[c];
        end else if (tick_c && run_q[c]) begin
          cnt_q[c] <= fire_c[c] ? period_q[c] : cnt_q[c] - CNT_W'(1);
        end
        reload_q[c] <= wr_period_c[c];
        if (wr_period_c[c]) begin
          period_q[c] <= bus.writedata[CNT_W-1:0];
        end
        if (wr_snap_c[c]) begin
          snap_q[c] <= cnt_q[c];
        end
        if (wr_ctrl_c[c]) begin
          ie_q[c]   <= bus.writedata[0];
          cont_q[c] <= bus.writedata[1];
        end
        if (fire_c[c]) begin
          to_q[c] <= 1'b1;
        end else if (clr_c[c]) begin
          to_q[c] <= 1'b0;
        end
        if (start_c[c]) begin
          run_q[c] <= 1'b1;
        end else if (stop_c[c]) begin
          run_q[c] <= 1'b0;
        end
      end
    end
  end

  // Shared prescaler; a PRESC write restarts the divide phase immediately.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
      pcnt_q  <= '0;
    end else if (wr_presc_c) begin
      presc_q <= bus.writedata[PRESC_W-1:0];
      pcnt_q  <= bus.writedata[PRESC_W-1:0];
    end else if (tick_c) begin
      pcnt_q  <= presc_q;
    end else begin
      pcnt_q  <= pcnt_q - PRESC_W'(1);
    end
  end

  // Registered read data, held between reads
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.readdata <= '0;
    end else if (rd_c) begin
      bus.readdata <= rd_data_c;
    end
  end

  assign irq = |(to_q & ie_q);

endmodule

// File: tb/tb_mtl2_multi_timer.sv
// Bench for mtl2_multi_timer: directed scenarios with literal expectations,
// then random bus traffic, all tracked by a cycle-level behavioural model.
module tb_mtl2_multi_timer;

  localparam int unsigned NUM_CH  = 2;
  localparam int unsigned CNT_W   = 24;
  localparam int unsigned PRESC_W = 8;
  localparam int unsigned DEF_P   = 19999;
  localparam int unsigned ADDR_W  = 4;
  localparam logic [31:0] CMASK   = 32'((64'd1 << CNT_W) - 64'd1);
  localparam logic [31:0] PMASK   = 32'((64'd1 << PRESC_W) - 64'd1);

  logic clk = 1'b0;
  logic reset;
  logic irq;

  mtl2_multi_timer_if #(.ADDR_W(ADDR_W)) bus ();

  mtl2_multi_timer #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRESC_W(PRESC_W), .DEFAULT_PERIOD(DEF_P)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  bit cmp_en = 1'b0;

  // Behavioural model state
  logic [31:0] m_cnt [NUM_CH];
  logic [31:0] m_period [NUM_CH];
  logic [31:0] m_snap [NUM_CH];
  bit          m_run [NUM_CH];
  bit          m_to [NUM_CH];
  bit          m_ie [NUM_CH];
  bit          m_cont [NUM_CH];
  bit          m_reload [NUM_CH];
  logic [31:0] m_presc, m_pcnt, m_rdata;

  function automatic logic [31:0] model_read(input int slot, input int off);
    logic [31:0] v = 0;
    if (slot < NUM_CH) begin
      case (off)
        0: v = {30'd0, m_run[slot], m_to[slot]};
        1: v = {30'd0, m_cont[slot], m_ie[slot]};
        2: v = m_period[slot];
        default: v = m_snap[slot];
      endcase
    end else if (slot == NUM_CH) begin
      if (off == 0) begin
        for (int c = 0; c < NUM_CH; c++) v[c] = m_to[c];
      end else if (off == 2) begin
        v = m_presc;
      end
    end
    return v;
  endfunction

  function automatic logic model_irq();
    for (int c = 0; c < NUM_CH; c++) if (m_to[c] && m_ie[c]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step();
    logic wr, rd, tick;
    int slot, off;
    logic [31:0] wd;
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        m_cnt[c] = DEF_P; m_period[c] = DEF_P; m_snap[c] = 0;
        m_run[c] = 0; m_to[c] = 0; m_ie[c] = 0; m_cont[c] = 0; m_reload[c] = 0;
      end
      m_presc = 0; m_pcnt = 0; m_rdata = 0;
      return;
    end
    wr   = bus.chipselect && !bus.write_n;
    rd   = bus.chipselect && bus.write_n;
    slot = int'(bus.address) >> 2;
    off  = int'(bus.address) & 3;
    wd   = bus.writedata;
    tick = (m_pcnt == 0);
    if (rd) m_rdata = model_read(slot, off);
    for (int c = 0; c < NUM_CH; c++) begin
      logic mine, fire, nrun, nto;
      logic [31:0] ncnt;
      mine = wr && (slot == c);
      fire = tick && m_run[c] && (m_cnt[c] == 0);
      if (m_reload[c]) ncnt = m_period[c];
      else if (tick && m_run[c]) ncnt = fire ? m_period[c] : m_cnt[c] - 1;
      else ncnt = m_cnt[c];
      if (fire) nto = 1;
      else if ((mine && off == 0) || (wr && slot == NUM_CH && off == 0 && wd[c])) nto = 0;
      else nto = m_to[c];
      if (mine && off == 1 && wd[2]) nrun = 1;
      else if (wr && slot == NUM_CH && off == 1 && wd[c]) nrun = 1;
      else if (mine && off == 1 && wd[3]) nrun = 0;
      else if (mine && off == 2) nrun = 0;
      else if (fire && !m_cont[c]) nrun = 0;
      else nrun = m_run[c];
      if (mine && off == 3) m_snap[c] = m_cnt[c];
      if (mine && off == 1) begin m_ie[c] = wd[0]; m_cont[c] = wd[1]; end
      m_reload[c] = mine && (off == 2);
      if (mine && off == 2) m_period[c] = wd & CMASK;
      m_cnt[c] = ncnt; m_to[c] = nto; m_run[c] = nrun;
    end
    if (wr && slot == NUM_CH && off == 2) begin
      m_presc = wd & PMASK; m_pcnt = wd & PMASK;
    end else if (m_pcnt == 0) begin
      m_pcnt = m_presc;
    end else begin
      m_pcnt = m_pcnt - 1;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Every-cycle comparison of DUT outputs against the model
  initial forever begin
    @(negedge clk);
    cyc++;
    if (cmp_en) begin
      n_vec++;
      if (irq !== model_irq()) begin
        n_err++;
        $display("FAIL irq cycle %0d: got %b expected %b", cyc, irq, model_irq());
      end
      n_vec++;
      if (bus.readdata !== m_rdata) begin
        n_err++;
        $display("FAIL readdata cycle %0d: got 0x%0h expected 0x%0h", cyc, bus.readdata, m_rdata);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic bus_write(input int a, input logic [31:0] d);
    bus.address = ADDR_W'(a); bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.writedata = d;
    @(negedge clk);
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
  endtask

  task automatic bus_read(input int a, output logic [31:0] d);
    bus.address = ADDR_W'(a); bus.chipselect = 1'b1; bus.write_n = 1'b1;
    @(negedge clk);
    d = bus.readdata;
    bus.chipselect = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_irq(input string name, input int max, output int n);
    n = 0;
    while (!irq && n < max) begin
      @(negedge clk);
      n++;
    end
    if (!irq) begin
      n_vec++; n_err++;
      $display("FAIL %s: irq timeout after %0d cycles, required high", name, n);
    end
  endtask

  function automatic int ch(input int c, input int off);
    return c * 4 + off;
  endfunction

  localparam int G_PEND = NUM_CH * 4, G_GSTART = NUM_CH * 4 + 1, G_PRESC = NUM_CH * 4 + 2;

  initial begin
    logic [31:0] d;
    int n, hits, r, a;
    bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    cmp_en = 1'b1;

    // Reset state
    check("reset_irq", 32'(irq), 0);
    bus_read(ch(0, 0), d); check("reset_status0", d, 0);
    bus_read(ch(0, 2), d); check("reset_period0", d, DEF_P);
    bus_read(ch(1, 3), d); check("reset_snap1", d, 0);
    bus_read(G_PRESC, d);  check("reset_presc", d, 0);

    // Continuous, PRESC=0, PERIOD=4: TO every 5 clocks
    bus_write(ch(0, 2), 4);
    bus_write(ch(0, 1), 32'h7);
    wait_irq("cont_first", 40, n); check("cont_first_latency", n, 5);
    bus_write(ch(0, 0), 0);
    check("status_clear_irq", 32'(irq), 0);
    wait_irq("cont_second", 40, n); check("cont_second_latency", n, 4);
    bus_write(ch(0, 1), 32'h8);

    // One-shot
    bus_write(ch(0, 2), 4);
    bus_write(ch(0, 0), 0);
    bus_write(ch(0, 1), 32'h5);
    wait_irq("oneshot", 40, n); check("oneshot_latency", n, 5);
    bus_read(ch(0, 0), d); check("oneshot_status", d, 32'h1);
    bus_write(ch(0, 3), 0);
    bus_read(ch(0, 3), d); check("oneshot_snap", d, 4);
    bus_write(ch(0, 0), 0);
    hits = 0;
    repeat (20) begin @(negedge clk); if (irq) hits++; end
    check("oneshot_no_second", hits, 0);

    // Prescaled: PRESC=3, PERIOD=2, start aligned to a prescaler tick
    bus_write(ch(1, 2), 2);
    bus_write(G_PRESC, 3);
    idle(3);
    bus_write(ch(1, 1), 32'h7);
    wait_irq("presc", 60, n); check("presc_latency", n, 12);
    bus_write(ch(1, 1), 32'h8);
    bus_write(G_PEND, 3);
    bus_write(G_PRESC, 0);

    // Global start
    bus_write(ch(0, 2), 9);
    bus_write(ch(1, 2), 9);
    bus_write(ch(0, 1), 32'h3);
    bus_write(ch(1, 1), 32'h3);
    bus_write(G_GSTART, 3);
    wait_irq("gstart", 40, n); check("gstart_latency", n, 10);
    bus_read(G_PEND, d); check("gstart_pend", d, 3);
    bus_write(G_PEND, 1);
    bus_read(G_PEND, d); check("pend_partial_clear", d, 2);
    check("pend_irq_held", 32'(irq), 1);

    // PERIOD write while running stops and reloads
    bus_write(ch(0, 2), 7);
    bus_read(ch(0, 0), d); check("period_wr_stops", d, 0);
    bus_write(ch(0, 3), 0);
    bus_read(ch(0, 3), d); check("period_wr_snap", d, 7);

    // STATUS clear on the same edge as a new timeout: set wins
    bus_write(G_PEND, 3);
    wait_irq("coincide", 40, n);
    idle(9);
    bus_write(ch(1, 0), 0);
    bus_read(ch(1, 0), d); check("clear_vs_set", d, 32'h3);

    // Reset mid-count
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    check("midreset_irq", 32'(irq), 0);
    bus_read(ch(1, 0), d); check("midreset_status1", d, 0);
    bus_read(ch(1, 2), d); check("midreset_period1", d, DEF_P);
    bus_read(ch(1, 1), d); check("midreset_ctrl1", d, 0);
    bus_read(G_PEND, d);   check("midreset_pend", d, 0);
    bus_write(13, 32'hFFFF_FFFF);
    bus_read(13, d);       check("unmapped_read", d, 0);
    bus_read(G_PEND + 3, d); check("global_off3", d, 0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      bus.chipselect = 1'b0; bus.write_n = 1'b1; reset = 1'b0;
      r = int'($urandom_range(0, 399));
      a = int'($urandom_range(0, 15));
      bus.address = ADDR_W'(a);
      if (r < 1) begin
        reset = 1'b1;
      end else if (r < 160) begin
        bus.chipselect = 1'b1;
      end else if (r < 280) begin
        bus.chipselect = 1'b1; bus.write_n = 1'b0;
        if (a < NUM_CH * 4 && (a & 3) == 2) bus.writedata = $urandom_range(0, 12);
        else if (a < NUM_CH * 4 && (a & 3) == 1) bus.writedata = $urandom_range(0, 15) | ($urandom_range(0, 1) << 2);
        else if (a == G_PRESC) bus.writedata = $urandom_range(0, 3);
        else bus.writedata = $urandom;
      end
      @(negedge clk);
    end
    bus.chipselect = 1'b0; bus.write_n = 1'b1; reset = 1'b0;
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
